// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between the instruction-fetch and data ports.
// Data wins by default; a consecutive-data-grant limit keeps instruction fetch moving.
module mem_arbiter #(
    parameter int RD_LAT   = 1,
    parameter int MAX_DWIN = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i_req_i,
    input  logic [31:0] i_addr_i,
    output logic [31:0] i_rdata_o,
    output logic        i_ack_o,
    input  logic        d_req_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [3:0]  d_we_i,
    output logic [31:0] d_rdata_o,
    output logic        d_ack_o,
    output logic        m_en_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    output logic [3:0]  m_we_o,
    input  logic [31:0] m_rdata_i
);
    // state  | meaning
    // IDLE   | no access in flight, waiting for a request
    // ISSUE  | memory strobe driven from the grant latch
    // WAIT   | read latency countdown; m_rdata captured on the last cycle
    // RESP   | ack to the granted port; next grant may be taken here
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);
    localparam logic [3:0] DWIN_MAX = 4'(MAX_DWIN);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  streak_q, streak_d;
    logic        gnt_d_q, gnt_d_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        any_req;
    logic        pick_d;
    logic        take;

    assign any_req = i_req_i | d_req_i;
    // Data is chosen unless instruction fetch has waited through MAX_DWIN data grants.
    assign pick_d  = d_req_i & ~(i_req_i & (streak_q >= DWIN_MAX));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        streak_d  = streak_q;
        gnt_d_d   = gnt_d_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        take      = 1'b0;
        m_en_o    = 1'b0;
        m_addr_o  = '0;
        m_wdata_o = '0;
        m_we_o    = '0;
        i_ack_o   = 1'b0;
        d_ack_o   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                take = any_req;
            end
            S_ISSUE: begin
                m_en_o    = 1'b1;
                m_addr_o  = addr_q;
                m_wdata_o = wdata_q;
                m_we_o    = we_q;
                cnt_d     = LAT_LOAD;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    if (!gnt_d_q) begin
                        i_rdata_d = m_rdata_i;
                    end else if (we_q == 4'd0) begin
                        d_rdata_d = m_rdata_i;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                i_ack_o = ~gnt_d_q;
                d_ack_o = gnt_d_q;
                state_d = S_IDLE;
                take    = any_req;
            end
        endcase

        if (take) begin
            state_d = S_ISSUE;
            gnt_d_d = pick_d;
            addr_d  = pick_d ? d_addr_i : i_addr_i;
            wdata_d = pick_d ? d_wdata_i : 32'd0;
            we_d    = pick_d ? d_we_i : 4'd0;
            if (!pick_d) begin
                streak_d = 4'd0;
            end else if (streak_q != 4'd15) begin
                streak_d = streak_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            streak_q  <= '0;
            gnt_d_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            streak_q  <= streak_d;
            gnt_d_q   <= gnt_d_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign i_rdata_o = i_rdata_q;
    assign d_rdata_o = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cases plus random traffic checked against a
// transaction-level model of grant order, timing and memory contents.
module tb_mem_arbiter;
    localparam int LAT  = 1;
    localparam int MAXD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        i_req, i_ack, d_req, d_ack, m_en;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic [3:0]  d_we, m_we;

    logic        b_i_req, b_i_ack, b_d_req, b_d_ack, b_m_en;
    logic [31:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata, b_m_addr, b_m_wdata, b_m_rdata;
    logic [3:0]  b_d_we, b_m_we;

    mem_arbiter #(.RD_LAT(LAT), .MAX_DWIN(MAXD)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .i_req_i(i_req), .i_addr_i(i_addr), .i_rdata_o(i_rdata), .i_ack_o(i_ack),
        .d_req_i(d_req), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_we_i(d_we),
        .d_rdata_o(d_rdata), .d_ack_o(d_ack),
        .m_en_o(m_en), .m_addr_o(m_addr), .m_wdata_o(m_wdata), .m_we_o(m_we), .m_rdata_i(m_rdata)
    );

    mem_arbiter #(.RD_LAT(3), .MAX_DWIN(4)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .i_req_i(b_i_req), .i_addr_i(b_i_addr), .i_rdata_o(b_i_rdata), .i_ack_o(b_i_ack),
        .d_req_i(b_d_req), .d_addr_i(b_d_addr), .d_wdata_i(b_d_wdata), .d_we_i(b_d_we),
        .d_rdata_o(b_d_rdata), .d_ack_o(b_d_ack),
        .m_en_o(b_m_en), .m_addr_o(b_m_addr), .m_wdata_o(b_m_wdata), .m_we_o(b_m_we), .m_rdata_i(b_m_rdata)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = -1;

    // Reference model: one outstanding access, described by its issue/ack cycles.
    int          e_iss, e_ack, next_dec, streak, rd_due;
    logic        e_isd, ack_i_now, ack_d_now;
    logic [31:0] e_addr, e_wdata, e_i_rdata, e_d_rdata, rd_addr;
    logic [3:0]  e_we;
    logic [31:0] emem [logic [31:0]];
    logic [31:0] mmem [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] erd(input logic [31:0] a);
        return emem.exists(a) ? emem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] mrd(input logic [31:0] a);
        return mmem.exists(a) ? mmem[a] : init_word(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_iss = -1; e_ack = -1; next_dec = 0; streak = 0; rd_due = -1;
        e_i_rdata = '0; e_d_rdata = '0;
    endtask

    task automatic begin_cycle();
        logic in_iss, in_ack;
        @(negedge clk);
        cyc++;
        in_iss = rst_n && (cyc == e_iss);
        in_ack = rst_n && (cyc == e_ack);
        ack_i_now = in_ack && !e_isd;
        ack_d_now = in_ack && e_isd;
        if (ack_i_now) e_i_rdata = mrd(e_addr);
        if (ack_d_now && e_we == 4'd0) e_d_rdata = mrd(e_addr);
        chk("m_en", 32'(m_en), 32'(in_iss));
        chk("m_addr", m_addr, in_iss ? e_addr : 32'd0);
        chk("m_we", 32'(m_we), 32'(in_iss ? e_we : 4'd0));
        if (!(in_iss && !e_isd)) chk("m_wdata", m_wdata, in_iss ? e_wdata : 32'd0);
        chk("i_ack", 32'(i_ack), 32'(ack_i_now));
        chk("d_ack", 32'(d_ack), 32'(ack_d_now));
        chk("i_rdata", i_rdata, e_i_rdata);
        chk("d_rdata", d_rdata, e_d_rdata);
        // Memory environment: reacts to the bus and returns data only on the valid edge.
        if (m_en === 1'b1) begin
            if (m_we != 4'd0) emem[m_addr] = merge(erd(m_addr), m_wdata, m_we);
            else begin
                rd_due  = cyc + LAT;
                rd_addr = m_addr;
            end
        end
        m_rdata = (cyc == rd_due) ? erd(rd_addr) : $urandom();
    endtask

    task automatic drive(input int mode);
        if (mode == 0) begin
            if (ack_i_now) i_req = 1'b0;
            if (ack_d_now) d_req = 1'b0;
        end else if (mode == 2) begin
            if (ack_i_now || !i_req) begin
                i_req = ($urandom_range(0, 2) == 0);
                if (i_req) i_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (ack_d_now || !d_req) begin
                d_req = ($urandom_range(0, 1) == 0);
                if (d_req) begin
                    d_addr  = 32'($urandom_range(0, 15)) << 2;
                    d_wdata = $urandom();
                    d_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
                end
            end
        end
    endtask

    task automatic decide();
        logic gd;
        if (rst_n && cyc >= next_dec && (i_req || d_req)) begin
            gd      = d_req && !(i_req && streak >= MAXD);
            streak  = gd ? ((streak < 15) ? streak + 1 : 15) : 0;
            e_isd   = gd;
            e_addr  = gd ? d_addr : i_addr;
            e_we    = gd ? d_we : 4'd0;
            e_wdata = d_wdata;
            e_iss   = cyc + 1;
            e_ack   = cyc + LAT + 2;
            next_dec = e_ack;
            if (gd && d_we != 4'd0) mmem[d_addr] = merge(mrd(d_addr), d_wdata, d_we);
        end
    endtask

    task automatic finish_cycle(input int mode);
        drive(mode);
        decide();
    endtask

    task automatic tick(input int mode);
        begin_cycle();
        finish_cycle(mode);
    endtask

    initial begin
        int t0, n_d, first_i;
        i_req = 0; i_addr = 0; d_req = 0; d_addr = 0; d_wdata = 0; d_we = 0; m_rdata = 0;
        b_i_req = 0; b_i_addr = 0; b_d_req = 0; b_d_addr = 0; b_d_wdata = 0; b_d_we = 0; b_m_rdata = 0;
        model_reset();
        #2 rst_n = 1'b0;
        repeat (3) tick(0);
        begin_cycle(); rst_n = 1'b1; finish_cycle(0);
        repeat (2) tick(0);

        // Instruction read
        begin_cycle(); t0 = cyc;
        emem[32'h10] = 32'h0050_0093; mmem[32'h10] = 32'h0050_0093;
        i_req = 1; i_addr = 32'h10;
        finish_cycle(0);
        repeat (5) begin
            begin_cycle();
            if (cyc == t0 + 1) chk("t1_issue_addr", m_addr, 32'h10);
            if (cyc == t0 + 3) begin
                chk("t1_i_ack", 32'(i_ack), 32'd1);
                chk("t1_i_rdata", i_rdata, 32'h0050_0093);
            end
            finish_cycle(0);
        end

        // Byte store, then read it back
        begin_cycle(); t0 = cyc;
        d_req = 1; d_addr = 32'h102; d_we = 4'b0100; d_wdata = 32'h00AB_0000;
        finish_cycle(0);
        repeat (5) begin
            begin_cycle();
            if (cyc == t0 + 1) begin
                chk("t3_m_we", 32'(m_we), 32'b0100);
                chk("t3_m_wdata", m_wdata, 32'h00AB_0000);
            end
            if (cyc == t0 + 3) begin
                chk("t3_d_ack", 32'(d_ack), 32'd1);
                chk("t3_d_rdata_held", d_rdata, 32'd0);
            end
            finish_cycle(0);
        end
        begin_cycle(); d_req = 1; d_we = 4'd0; finish_cycle(0);
        repeat (5) tick(0);

        // Simultaneous requests; address change after grant must be ignored
        begin_cycle(); t0 = cyc;
        i_req = 1; i_addr = 32'h20; d_req = 1; d_addr = 32'h200; d_we = 4'd0;
        finish_cycle(0);
        repeat (8) begin
            begin_cycle();
            if (cyc == t0 + 1) begin
                chk("t2_first_addr", m_addr, 32'h200);
                d_addr = 32'hFFFF_FFF0;
            end
            if (cyc == t0 + 3) chk("t2_d_ack", 32'(d_ack), 32'd1);
            if (cyc == t0 + 4) chk("t2_second_addr", m_addr, 32'h20);
            if (cyc == t0 + 6) chk("t2_i_ack", 32'(i_ack), 32'd1);
            finish_cycle(0);
        end

        // Starvation limit with both requests held
        begin_cycle(); t0 = cyc;
        i_req = 1; i_addr = 32'h40; d_req = 1; d_addr = 32'h44; d_we = 4'd0;
        finish_cycle(1);
        n_d = 0; first_i = -1;
        repeat (20) begin
            begin_cycle();
            if (first_i < 0 && d_ack === 1'b1) n_d++;
            if (first_i < 0 && i_ack === 1'b1) first_i = cyc - t0;
            finish_cycle(first_i < 0 ? 1 : 0);
        end
        chk("t4_i_ack_cycle", 32'(first_i), 32'd15);
        chk("t4_d_acks_before_i", 32'(n_d), 32'd4);
        repeat (3) tick(0);

        // Reset during WAIT, released with a fresh instruction request
        begin_cycle(); t0 = cyc; i_req = 1; i_addr = 32'h30; finish_cycle(0);
        tick(0);
        begin_cycle();
        rst_n = 1'b0;
        #1;
        chk("t6_m_en", 32'(m_en), 32'd0);
        chk("t6_m_addr", m_addr, 32'd0);
        chk("t6_i_ack", 32'(i_ack), 32'd0);
        chk("t6_i_rdata", i_rdata, 32'd0);
        chk("t6_d_rdata", d_rdata, 32'd0);
        model_reset();
        i_addr = 32'h34;
        finish_cycle(0);
        begin_cycle(); rst_n = 1'b1; finish_cycle(0);
        begin_cycle();
        chk("t6_reissue_en", 32'(m_en), 32'd1);
        chk("t6_reissue_addr", m_addr, 32'h34);
        finish_cycle(0);
        repeat (4) tick(0);

        // Random traffic
        repeat (3000) tick(2);
        repeat (30) tick(0);

        // Latency 3 instance
        begin_cycle(); t0 = cyc;
        b_i_req = 1; b_i_addr = 32'h40; b_m_rdata = 32'h1111_1111;
        finish_cycle(0);
        for (int k = 1; k <= 6; k++) begin
            begin_cycle();
            chk("t5_m_en", 32'(b_m_en), 32'(k == 1));
            if (k == 1) chk("t5_m_addr", b_m_addr, 32'h40);
            chk("t5_i_ack", 32'(b_i_ack), 32'(k == 5));
            if (k == 4) chk("t5_rdata_early", b_i_rdata, 32'd0);
            if (k == 5) begin
                chk("t5_i_rdata", b_i_rdata, 32'hCAFE_F00D);
                b_i_req = 0;
            end
            b_m_rdata = (k == 4) ? 32'hCAFE_F00D : 32'h1111_1111 + 32'(k);
            finish_cycle(0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
